// File: rtl/accel_tilt_filter.sv
// accel_tilt_filter: periodic sampling, block averaging, dead-zone and sign-extension of accelerometer X/Y.
// Optional clamp of the conditioned value to +/-SAT_LIMIT when TILT_SATURATE_EN is defined.
module accel_tilt_filter #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 1_000,
    parameter int AVG_LOG2  = 3,
    parameter int DEADZONE  = 8,
    parameter int SAT_LIMIT = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  raw_x_in,
    input  logic [8:0]  raw_y_in,
    output logic [31:0] tilt_x_out,
    output logic [31:0] tilt_y_out,
    output logic        tilt_valid
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW  = 9 + AVG_LOG2;
`ifdef TILT_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    logic [8:0]           rx_q, ry_q, zx_q, zx_d, zy_q, zy_d;
    logic [CW-1:0]        div_q, div_d;
    logic [BW-1:0]        blk_q, blk_d;
    logic signed [AW-1:0] ax_q, ax_d, ay_q, ay_d, sx, sy;
    logic                 vld_q, vld_d, tick, last;
    // Block average (floor), then dead-zone, then optional clamp.
    function automatic logic [8:0] cond(input logic signed [AW-1:0] sum);
        logic signed [8:0] avg;
        avg = 9'(sum >>> AVG_LOG2);
        cond = (avg >= -DEADZONE && avg <= DEADZONE) ? 9'd0 :
               (SAT_EN && avg > SAT_LIMIT)           ? 9'(SAT_LIMIT) :
               (SAT_EN && avg < -SAT_LIMIT)          ? 9'(-SAT_LIMIT) : avg;
    endfunction
    always_comb begin
        tick  = div_q == CW'(DIV - 1);
        last  = tick && (AVG_LOG2 == 0 || blk_q == BW'((1 << AVG_LOG2) - 1));
        sx    = ax_q + AW'($signed(rx_q));
        sy    = ay_q + AW'($signed(ry_q));
        div_d = tick ? '0 : div_q + 1'b1;
        blk_d = last ? '0 : tick ? blk_q + 1'b1 : blk_q;
        ax_d  = last ? '0 : tick ? sx : ax_q;
        ay_d  = last ? '0 : tick ? sy : ay_q;
        zx_d  = last ? cond(sx) : zx_q;
        zy_d  = last ? cond(sy) : zy_q;
        vld_d = last;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_q  <= '0;
            ry_q  <= '0;
            div_q <= '0;
            blk_q <= '0;
            ax_q  <= '0;
            ay_q  <= '0;
            zx_q  <= '0;
            zy_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            rx_q  <= raw_x_in;
            ry_q  <= raw_y_in;
            div_q <= div_d;
            blk_q <= blk_d;
            ax_q  <= ax_d;
            ay_q  <= ay_d;
            zx_q  <= zx_d;
            zy_q  <= zy_d;
            vld_q <= vld_d;
        end
    end
    assign tilt_x_out = {{23{zx_q[8]}}, zx_q};
    assign tilt_y_out = {{23{zy_q[8]}}, zy_q};
    assign tilt_valid = vld_q;
endmodule

// File: tb/tb_accel_tilt_filter.sv
// tb_accel_tilt_filter: directed stimulus, block-average reference model and per-cycle compare.
// Two instances share the inputs: dut_a uses DEADZONE=4, dut_b DEADZONE=0; both SAT_LIMIT=100.
module tb_accel_tilt_filter;
    localparam int DIV = 10;
    localparam int N   = 4;
`ifdef TILT_SATURATE_EN
    localparam int SAT = 100;
`else
    localparam int SAT = 0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  raw_x, raw_y;
    logic [31:0] xa, ya, xb, yb;
    logic        va, vb;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    accel_tilt_filter #(.CLK_HZ(1000), .SAMPLE_HZ(100), .AVG_LOG2(2), .DEADZONE(4), .SAT_LIMIT(100)) dut_a (
        .clock(clk), .reset(rst), .raw_x_in(raw_x), .raw_y_in(raw_y),
        .tilt_x_out(xa), .tilt_y_out(ya), .tilt_valid(va));
    accel_tilt_filter #(.CLK_HZ(1000), .SAMPLE_HZ(100), .AVG_LOG2(2), .DEADZONE(0), .SAT_LIMIT(100)) dut_b (
        .clock(clk), .reset(rst), .raw_x_in(raw_x), .raw_y_in(raw_y),
        .tilt_x_out(xb), .tilt_y_out(yb), .tilt_valid(vb));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int expect_out(input int sum, input int dz);
        int avg;
        avg = sum / N;
        if (sum % N != 0 && sum < 0) avg -= 1;
        if (avg <= dz && avg >= -dz) return 0;
        if (SAT != 0 && avg > SAT) return SAT;
        if (SAT != 0 && avg < -SAT) return -SAT;
        return avg;
    endfunction
    // Reference model: each tick edge takes the raw value present at the previous edge.
    int e = 0, px = 0, py = 0;
    int qx[$], qy[$];
    int ex[2] = '{0, 0};
    int ey[2] = '{0, 0};
    bit ev = 0, pva = 0;
    initial forever begin
        @(posedge clk);
        if (rst) begin
            e = 0;
            ev = 0;
            ex = '{0, 0};
            ey = '{0, 0};
            qx.delete();
            qy.delete();
        end else begin
            e++;
            ev = 0;
            if (e % DIV == 0) begin
                qx.push_back(px);
                qy.push_back(py);
                if (qx.size() == N) begin
                    int sxv, syv;
                    sxv = 0;
                    syv = 0;
                    foreach (qx[i]) begin
                        sxv += qx[i];
                        syv += qy[i];
                    end
                    ex = '{expect_out(sxv, 4), expect_out(sxv, 0)};
                    ey = '{expect_out(syv, 4), expect_out(syv, 0)};
                    ev = 1;
                    qx.delete();
                    qy.delete();
                end
            end
        end
        px = rst ? 0 : int'($signed(raw_x));
        py = rst ? 0 : int'($signed(raw_y));
        #1;
        chk("valid_a", {31'b0, va}, {31'b0, ev});
        chk("valid_b", {31'b0, vb}, {31'b0, ev});
        chk("x_a", xa, ex[0]);
        chk("y_a", ya, ey[0]);
        chk("x_b", xb, ex[1]);
        chk("y_b", yb, ey[1]);
        chk("no_double_valid", {31'b0, va & pva}, 32'd0);
        pva = va;
    end
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int n;
        rst = 1'b1;
        raw_x = 9'd0;
        raw_y = 9'd0;
        wait_n(3);
        chk("rst_x", xa, 32'd0);
        chk("rst_valid", {31'b0, va}, 32'd0);
        raw_x = 9'd50;
        raw_y = 9'h1EC;
        rst = 1'b0;
        wait_n(39);
        chk("t1_valid_e39", {31'b0, va}, 32'd0);
        wait_n(1);
        chk("t1_valid_e40", {31'b0, va}, 32'd1);
        chk("t1_x", xa, 32'd50);
        chk("t1_y", ya, 32'hFFFFFFEC);
        wait_n(1);
        chk("t1_valid_e41", {31'b0, va}, 32'd0);
        raw_x = 9'd3;
        wait_n(39);
        chk("t2_dz_x3_a", xa, 32'd0);
        chk("t2_dz_x3_b", xb, 32'd3);
        raw_x = 9'd5;
        wait_n(40);
        chk("t2_dz_x5_a", xa, 32'd5);
        raw_x = 9'd3;
        wait_n(10);
        raw_x = 9'd4;
        wait_n(30);
        chk("t3_floor_pos", xb, 32'd3);
        raw_x = 9'h1FD;
        wait_n(10);
        raw_x = 9'h1FC;
        wait_n(30);
        chk("t3_floor_neg_b", xb, 32'hFFFFFFFC);
        chk("t3_floor_neg_a", xa, 32'd0);
        raw_x = 9'd200;
        wait_n(40);
        chk("t5_sat_pos", xa, SAT != 0 ? 32'd100 : 32'd200);
        raw_x = 9'h138;
        wait_n(40);
        chk("t5_sat_neg", xa, SAT != 0 ? -32'sd100 : -32'sd200);
        raw_x = 9'd8;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            raw_x = raw_x ^ 9'd8;
        end
        chk("t6_toggle_a", xa, 32'd8);
        chk("t6_toggle_b", xb, 32'd8);
        wait_n(25);
        rst = 1'b1;
        #1;
        chk("t4_async_x", xa, 32'd0);
        chk("t4_async_y", ya, 32'd0);
        chk("t4_async_valid", {31'b0, va}, 32'd0);
        wait_n(1);
        rst = 1'b0;
        n = 0;
        while (n < 100 && !va) begin
            @(negedge clk);
            n++;
        end
        chk("t4_latency", n, 32'd40);
        wait_n(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
